mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 146 ++++++++++++++
 tb/tb_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one load/store at a time, waits a
// fixed latency, performs one little-endian word-storage access and holds the response.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic        armed;
  logic        accept;

  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_word;
  logic          access_err;
  logic [31:0]   load_val;
  logic [31:0]   store_val;

  function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr);
    logic err;
    case (size)
      2'b01:   err = addr[0];
      2'b10:   err = (addr[1:0] != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
    return err | (addr[31:2] >= 30'(DEPTH_WORDS));
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] w;
    w = old;
    case (size)
      2'b00:   w[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) w[31:16] = wdata[15:0];
        else        w[15:0]  = wdata[15:0];
      end
      default: w = wdata;
    endcase
    return w;
  endfunction

  // armed keeps req_ready low until the first clock edge after reset release
  assign req_ready  = armed && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  assign word_idx   = addr_q[AW+1:2];
  assign mem_word   = mem[word_idx];
  assign access_err = access_error(size_q, addr_q);
  assign load_val   = extend_load(mem_word, size_q, addr_q[1:0], unsigned_q);
  assign store_val  = merge_store(mem_word, wdata_q, size_q, addr_q[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      armed      <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_next;
      if (accept)
        wait_cnt <= WAIT_INIT;
      else if (state == WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (state == ACCESS) begin
        resp_err   <= access_err;
        resp_rdata <= (access_err || we_q) ? 32'd0 : load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q       <= req_we;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
    end
  end

  // Storage is never reset; an aborted request never reaches ACCESS, so it never writes
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && !access_err)
      mem[word_idx] <= store_val;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt <= 4'd1) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0,
// expected responses queued at issue time and compared when the response appears.
module tb_mem_responder;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        rv   [2];
  logic        rdy  [2];
  logic        rwe  [2];
  logic [1:0]  rsz  [2];
  logic        uns  [2];
  logic [31:0] ra   [2];
  logic [31:0] rwd  [2];
  logic        vld  [2];
  logic        rr   [2];
  logic [31:0] rdat [2];
  logic        rerr [2];

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]), .req_size(rsz[0]),
    .req_unsigned(uns[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
    .resp_valid(vld[0]), .resp_ready(rr[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0])
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_nowait (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]), .req_size(rsz[1]),
    .req_unsigned(uns[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
    .resp_valid(vld[1]), .resp_ready(rr[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic req_t mk(input logic we, input logic [1:0] size, input logic u,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err);
    req_t r;
    r.we = we; r.size = size; r.uns = u; r.addr = addr;
    r.wdata = wdata; r.rdata = rdata; r.err = err;
    return r;
  endfunction

  // Drives one request on instance s, waits for its response, then releases it.
  task automatic run_req(input int s, input req_t r, output int lat,
                         output logic [31:0] rd, output logic er, output bit to);
    int n;
    to = 0; lat = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    rv[s] = 1'b1; rwe[s] = r.we; rsz[s] = r.size; uns[s] = r.uns;
    ra[s] = r.addr; rwd[s] = r.wdata;
    n = 0;
    while (!rdy[s] && n < 50) begin @(negedge clk); n++; end
    if (!rdy[s]) begin rv[s] = 1'b0; to = 1; return; end
    @(posedge clk); #1 rv[s] = 1'b0;
    lat = 1;
    while (!vld[s] && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!vld[s]) begin to = 1; return; end
    rd = rdat[s]; er = rerr[s];
    @(negedge clk); rr[s] = 1'b1;
    @(posedge clk); #1 rr[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++; if (rdy[0] !== 1'b0) $display("FAIL reset_req_ready got %b want 0", rdy[0]); else passes++;
    checks++; if (vld[0] !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", vld[0]); else passes++;
    checks++; if (rdat[0] !== 32'd0) $display("FAIL reset_resp_rdata got %h want 0", rdat[0]); else passes++;
    checks++; if (rerr[0] !== 1'b0) $display("FAIL reset_resp_err got %b want 0", rerr[0]); else passes++;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    checks++; if (rdy[0] !== 1'b0) $display("FAIL release_before_edge req_ready got %b want 0", rdy[0]); else passes++;
    @(posedge clk); #1;
    checks++; if (rdy[0] !== 1'b1) $display("FAIL first_edge req_ready got %b want 1", rdy[0]); else passes++;
    checks++; if (rdy[1] !== 1'b1) $display("FAIL first_edge_nowait req_ready got %b want 1", rdy[1]); else passes++;
  endtask

  task automatic test_store_load();
    req_t t[$];
    int lat; logic [31:0] rd; logic er; bit to; exp_t e;
    t.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0));
    t.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0));
    t.push_back(mk(1, 2'b10, 0, 32'h00, 32'hA5A5A5A5, 32'h0, 0));
    t.push_back(mk(1, 2'b00, 0, 32'h11, 32'h12345680, 32'h0, 0));
    t.push_back(mk(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFF80, 0));
    t.push_back(mk(0, 2'b00, 1, 32'h11, 32'h0, 32'h00000080, 0));
    t.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0));
    t.push_back(mk(0, 2'b10, 1, 32'h10, 32'h0, 32'hDEAD80EF, 0));
    t.push_back(mk(1, 2'b10, 0, 32'h30, 32'h00000000, 32'h0, 0));
    t.push_back(mk(1, 2'b01, 0, 32'h32, 32'hFFFF1234, 32'h0, 0));
    t.push_back(mk(1, 2'b00, 0, 32'h30, 32'h000055AB, 32'h0, 0));
    t.push_back(mk(0, 2'b10, 0, 32'h30, 32'h0, 32'h123400AB, 0));
    t.push_back(mk(0, 2'b01, 1, 32'h32, 32'h0, 32'h00001234, 0));
    t.push_back(mk(0, 2'b01, 0, 32'h30, 32'h0, 32'h000000AB, 0));
    t.push_back(mk(0, 2'b00, 0, 32'h33, 32'h0, 32'h00000012, 0));
    t.push_back(mk(0, 2'b00, 0, 32'h30, 32'h0, 32'hFFFFFFAB, 0));
    t.push_back(mk(0, 2'b00, 1, 32'h30, 32'h0, 32'h000000AB, 0));
    t.push_back(mk(1, 2'b00, 0, 32'h33, 32'h000000C3, 32'h0, 0));
    t.push_back(mk(0, 2'b01, 0, 32'h32, 32'h0, 32'hFFFFC334, 0));
    t.push_back(mk(1, 2'b10, 0, 32'hFFC, 32'h600DCAFE, 32'h0, 0));
    t.push_back(mk(0, 2'b10, 0, 32'hFFC, 32'h0, 32'h600DCAFE, 0));
    foreach (t[i]) begin
      sb.push_back({t[i].err, t[i].rdata});
      run_req(0, t[i], lat, rd, er, to);
      e = sb.pop_front();
      checks++; if (to || lat != 4) $display("FAIL store_load[%0d] latency got %0d (timeout %0d) want 4", i, lat, to); else passes++;
      checks++; if (rd !== e.rdata) $display("FAIL store_load[%0d] rdata got %h want %h", i, rd, e.rdata); else passes++;
      checks++; if (er !== e.err) $display("FAIL store_load[%0d] err got %b want %b", i, er, e.err); else passes++;
    end
  endtask

  task automatic test_errors();
    req_t t[$];
    int lat; logic [31:0] rd; logic er; bit to; exp_t e;
    t.push_back(mk(0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1));
    t.push_back(mk(0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1));
    t.push_back(mk(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1));
    t.push_back(mk(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1));
    t.push_back(mk(1, 2'b10, 0, 32'h12, 32'hFFFFFFFF, 32'h0, 1));
    t.push_back(mk(1, 2'b01, 0, 32'h11, 32'h0000FFFF, 32'h0, 1));
    t.push_back(mk(1, 2'b11, 0, 32'h10, 32'h11111111, 32'h0, 1));
    t.push_back(mk(1, 2'b10, 0, 32'h1000, 32'h0BADF00D, 32'h0, 1));
    t.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0));
    t.push_back(mk(0, 2'b10, 0, 32'h00, 32'h0, 32'hA5A5A5A5, 0));
    foreach (t[i]) begin
      sb.push_back({t[i].err, t[i].rdata});
      run_req(0, t[i], lat, rd, er, to);
      e = sb.pop_front();
      checks++; if (to || lat != 4) $display("FAIL errors[%0d] latency got %0d (timeout %0d) want 4", i, lat, to); else passes++;
      checks++; if (rd !== e.rdata) $display("FAIL errors[%0d] rdata got %h want %h", i, rd, e.rdata); else passes++;
      checks++; if (er !== e.err) $display("FAIL errors[%0d] err got %b want %b", i, er, e.err); else passes++;
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic [31:0] snap; int n;
    sb.push_back({1'b0, 32'hDEAD80EF});
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b0; rsz[0] = 2'b10; uns[0] = 1'b0; ra[0] = 32'h10; rwd[0] = 32'h0;
    n = 0;
    while (!rdy[0] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 rv[0] = 1'b0;
    n = 0;
    while (!vld[0] && n < 40) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    snap = rdat[0];
    checks++; if (vld[0] !== 1'b1 || snap !== e.rdata) $display("FAIL hold_first rdata got %h valid %b want %h", snap, vld[0], e.rdata); else passes++;
    @(negedge clk);
    rv[0] = 1'b1; ra[0] = 32'h0;
    sb.push_back({1'b0, 32'hA5A5A5A5});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({vld[0], rdy[0], rerr[0], rdat[0]} !== {1'b1, 1'b0, 1'b0, snap})
        $display("FAIL hold_cycle%0d got valid %b ready %b err %b rdata %h want 1 0 0 %h", k, vld[0], rdy[0], rerr[0], rdat[0], snap);
      else passes++;
    end
    @(negedge clk) rr[0] = 1'b1;
    @(posedge clk); #1 rr[0] = 1'b0;
    checks++; if ({rdy[0], vld[0]} !== 2'b10) $display("FAIL hold_release got ready %b valid %b want 1 0", rdy[0], vld[0]); else passes++;
    @(posedge clk); #1;
    checks++; if (rdy[0] !== 1'b0) $display("FAIL held_req_accept req_ready got %b want 0", rdy[0]); else passes++;
    rv[0] = 1'b0;
    n = 0;
    while (!vld[0] && n < 40) begin @(posedge clk); #1; n++; end
    e = sb.pop_front();
    checks++; if (vld[0] !== 1'b1 || rdat[0] !== e.rdata) $display("FAIL held_req_resp rdata got %h valid %b want %h", rdat[0], vld[0], e.rdata); else passes++;
    @(negedge clk) rr[0] = 1'b1;
    @(posedge clk); #1 rr[0] = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er; bit to; exp_t e; bit seen; int n;
    req_t r;
    r = mk(1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0);
    run_req(0, r, lat, rd, er, to);
    checks++; if (to || er !== 1'b0) $display("FAIL abort_prep_store err got %b timeout %0d want 0", er, to); else passes++;
    r = mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0);
    sb.push_back({r.err, r.rdata});
    run_req(0, r, lat, rd, er, to);
    e = sb.pop_front();
    checks++; if (to || rd !== e.rdata) $display("FAIL abort_prep_load rdata got %h want %h", rd, e.rdata); else passes++;
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b1; rsz[0] = 2'b10; uns[0] = 1'b0; ra[0] = 32'h20; rwd[0] = 32'h12345678;
    n = 0;
    while (!rdy[0] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 rv[0] = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rdy[0], vld[0], rerr[0], rdat[0]} !== {1'b0, 1'b0, 1'b0, 32'd0})
      $display("FAIL abort_async_clear got ready %b valid %b err %b rdata %h want all 0", rdy[0], vld[0], rerr[0], rdat[0]);
    else passes++;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (vld[0] !== 1'b0) seen = 1;
    end
    checks++; if (seen) $display("FAIL abort_no_response resp_valid got 1 want 0"); else passes++;
    r = mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0);
    sb.push_back({r.err, r.rdata});
    run_req(0, r, lat, rd, er, to);
    e = sb.pop_front();
    checks++; if (to || rd !== e.rdata) $display("FAIL abort_storage_kept rdata got %h want %h", rd, e.rdata); else passes++;
    checks++; if (er !== e.err) $display("FAIL abort_storage_kept err got %b want %b", er, e.err); else passes++;
  endtask

  task automatic test_back_to_back();
    int acc[$]; int n; exp_t e; bit bad;
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b0; rsz[0] = 2'b10; uns[0] = 1'b0; ra[0] = 32'h10; rwd[0] = 32'h0;
    rr[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (vld[0]) begin
        e = sb.pop_front();
        checks++; if (rdat[0] !== e.rdata || rerr[0] !== e.err) $display("FAIL b2b_resp cycle %0d rdata %h err %b want %h %b", i, rdat[0], rerr[0], e.rdata, e.err); else passes++;
      end
      if (rdy[0]) begin
        acc.push_back(i);
        sb.push_back({1'b0, 32'hDEAD80EF});
      end
    end
    @(negedge clk) rv[0] = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      if (vld[0]) begin
        e = sb.pop_front();
        checks++; if (rdat[0] !== e.rdata || rerr[0] !== e.err) $display("FAIL b2b_drain rdata %h err %b want %h %b", rdat[0], rerr[0], e.rdata, e.err); else passes++;
      end
      @(negedge clk); n++;
    end
    rr[0] = 1'b0;
    checks++; if (sb.size() != 0) $display("FAIL b2b_drain pending got %0d want 0", sb.size()); else passes++;
    bad = (acc.size() < 5);
    for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 5) bad = 1;
    checks++; if (bad) $display("FAIL b2b_spacing accepts %0d first gap %0d want gaps of 5", acc.size(), (acc.size() > 1) ? acc[1] - acc[0] : -1); else passes++;
  endtask

  task automatic test_zero_wait();
    req_t t[$];
    int lat; logic [31:0] rd; logic er; bit to; exp_t e;
    t.push_back(mk(1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'h0, 0));
    t.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFFBEEF, 0));
    t.push_back(mk(0, 2'b01, 1, 32'h22, 32'h0, 32'h0000BEEF, 0));
    t.push_back(mk(0, 2'b10, 0, 32'h23, 32'h0, 32'h0, 1));
    foreach (t[i]) begin
      sb.push_back({t[i].err, t[i].rdata});
      run_req(1, t[i], lat, rd, er, to);
      e = sb.pop_front();
      checks++; if (to || lat != 2) $display("FAIL zero_wait[%0d] latency got %0d (timeout %0d) want 2", i, lat, to); else passes++;
      checks++; if (rd !== e.rdata) $display("FAIL zero_wait[%0d] rdata got %h want %h", i, rd, e.rdata); else passes++;
      checks++; if (er !== e.err) $display("FAIL zero_wait[%0d] err got %b want %b", i, er, e.err); else passes++;
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rv[s] = 1'b0; rwe[s] = 1'b0; rsz[s] = 2'b00; uns[s] = 1'b0;
      ra[s] = 32'h0; rwd[s] = 32'h0; rr[s] = 1'b0;
    end
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_zero_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
